mips_muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit with HI/LO registers for the MIPS core.

---
 rtl/mips_muldiv_unit.sv | 212 +++++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// ---------------------------------------------------------------------------
// mips_muldiv_unit
// Iterative multiply/divide unit with HI/LO registers for the MIPS core.
// It executes MULT/MULTU/DIV/DIVU through a shift-add or restoring-divide
// datapath, one bit per clock. MTHI/MTLO write HI/LO directly.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start_i   request, accepted only while idle
//   op_i      000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op
//   a_i       multiplicand / dividend / MTHI-MTLO data
//   b_i       multiplier / divisor
//   cancel_i  abort the in-flight operation
//   busy_o    operation in flight
//   done_o    one-cycle pulse; hi_o/lo_o hold the new result
//   div0_o    high with done_o when the divisor was zero
//   hi_o      HI register
//   lo_o      LO register
//
// state  | meaning
// S_IDLE | waiting for start_i; MTHI/MTLO handled here
// S_CALC | one multiply/divide iteration per clock, cnt counts down to 0
// S_FIX  | sign correction, HI/LO write, done_o pulse next cycle
// ---------------------------------------------------------------------------
module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cancel_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div0_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t state, state_next;

   logic [CW-1:0]      cnt;
   logic [WIDTH:0]     acc;       // product high half / partial remainder
   logic [WIDTH-1:0]   quo;       // multiplier shifting out / quotient shifting in
   logic [WIDTH-1:0]   opb;       // multiplicand / divisor magnitude
   logic               is_div;
   logic               sign_a;
   logic               sign_b;
   logic               b_zero;

   logic               accept_md;
   logic               accept_mt;
   logic               iter_en;
   logic               fix_en;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     acc_step;
   logic [WIDTH-1:0]   quo_step;

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   // op_i[0] selects the signed variant of both MULT and DIV
   assign a_neg  = op_i[0] & a_i[WIDTH-1];
   assign b_neg  = op_i[0] & b_i[WIDTH-1];
   assign a_abs  = a_neg ? -a_i : a_i;
   assign b_abs  = b_neg ? -b_i : b_i;

   assign busy_o = (state != S_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept_md  = 1'b0;
      accept_mt  = 1'b0;
      iter_en    = 1'b0;
      fix_en     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_i && !op_i[2]) begin
               accept_md  = 1'b1;
               state_next = S_CALC;
            end else if (start_i && (op_i[2:1] == 2'b10)) begin
               accept_mt  = 1'b1;
            end
         end
         S_CALC: begin
            if (cancel_i) begin
               state_next = S_IDLE;
            end else if (cnt == '0) begin
               state_next = S_FIX;
            end else begin
               iter_en    = 1'b1;
            end
         end
         S_FIX: begin
            state_next = S_IDLE;
            fix_en     = !cancel_i;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // One iteration step. The divide path shifts the next dividend bit into the
   // remainder and keeps the trial difference only when it did not borrow.
   always_comb begin
      mul_sum   = acc + (quo[0] ? {1'b0, opb} : '0);
      div_shift = {acc[WIDTH-1:0], quo[WIDTH-1]};
      div_trial = div_shift - {1'b0, opb};
      if (is_div) begin
         if (div_trial[WIDTH]) begin
            acc_step = div_shift;
            quo_step = {quo[WIDTH-2:0], 1'b0};
         end else begin
            acc_step = div_trial;
            quo_step = {quo[WIDTH-2:0], 1'b1};
         end
      end else begin
         acc_step = {1'b0, mul_sum[WIDTH:1]};
         quo_step = {mul_sum[0], quo[WIDTH-1:1]};
      end
   end

   // Sign correction. A zero divisor leaves the dividend magnitude in the
   // remainder, so restoring the dividend sign returns the original a_i in HI.
   always_comb begin
      prod     = {acc[WIDTH-1:0], quo};
      prod_fix = (sign_a ^ sign_b) ? -prod : prod;
      rem      = acc[WIDTH-1:0];
      if (is_div) begin
         fix_lo = b_zero ? '1 : ((sign_a ^ sign_b) ? -quo : quo);
         fix_hi = sign_a ? -rem : rem;
      end else begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         acc    <= '0;
         quo    <= '0;
         opb    <= '0;
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         b_zero <= 1'b0;
         done_o <= 1'b0;
         div0_o <= 1'b0;
         hi_o   <= '0;
         lo_o   <= '0;
      end else begin
         done_o <= fix_en;
         div0_o <= fix_en & is_div & b_zero;
         if (accept_md) begin
            cnt    <= CW'(WIDTH);
            acc    <= '0;
            quo    <= a_abs;
            opb    <= b_abs;
            is_div <= op_i[1];
            sign_a <= a_neg;
            sign_b <= b_neg;
            b_zero <= (b_i == '0);
         end else if (iter_en) begin
            cnt    <= cnt - 1'b1;
            acc    <= acc_step;
            quo    <= quo_step;
         end
         if (accept_mt) begin
            if (op_i[0]) begin
               lo_o <= a_i;
            end else begin
               hi_o <= a_i;
            end
         end
         if (fix_en) begin
            hi_o <= fix_hi;
            lo_o <= fix_lo;
         end
      end
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_muldiv_unit
// Self-checking bench for mips_muldiv_unit (WIDTH=32). A cycle-level reference
// model built on plain arithmetic tracks busy/done/div0/HI/LO and is compared
// with the DUT on every falling edge; directed cases pin literal results.
// ---------------------------------------------------------------------------
module tb_mips_muldiv_unit;

   localparam int W = 32;
   localparam logic [W-1:0] ONES = {W{1'b1}};
   localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_i;
   logic [2:0]   op_i;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         cancel_i;
   logic         busy_o;
   logic         done_o;
   logic         div0_o;
   logic [W-1:0] hi_o;
   logic [W-1:0] lo_o;

   always #5 clk = ~clk;

   mips_muldiv_unit #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (rst_n),
      .start_i  (start_i),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .cancel_i (cancel_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .div0_o   (div0_o),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
   );

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result of one operation: {div0, hi, lo}
   function automatic logic [2*W:0] ref_op(input logic [2:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
      longint      sx;
      longint      sy;
      logic [63:0] p;
      int          qi;
      int          ri;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p  = '0;
      case (op)
         3'd0: p = {32'd0, x} * {32'd0, y};
         3'd1: p = 64'(sx * sy);
         3'd2: begin
            if (y == '0) return {1'b1, x, ONES};
            return {1'b0, x % y, x / y};
         end
         3'd3: begin
            if (y == '0) return {1'b1, x, ONES};
            if (x == MIN && y == ONES) return {1'b0, {W{1'b0}}, MIN};
            qi = $signed(x) / $signed(y);
            ri = $signed(x) % $signed(y);
            return {1'b0, W'(ri), W'(qi)};
         end
         default: p = '0;
      endcase
      return {1'b0, p};
   endfunction

   // Reference model: results become visible W+2 edges after acceptance.
   logic         m_busy;
   logic         m_done;
   logic         m_div0;
   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;
   logic [W-1:0] p_hi;
   logic [W-1:0] p_lo;
   logic         p_div0;
   int           m_left;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_done = 1'b0; m_div0 = 1'b0;
         m_hi = '0; m_lo = '0; m_left = 0;
         p_hi = '0; p_lo = '0; p_div0 = 1'b0;
      end else begin
         m_done = 1'b0;
         m_div0 = 1'b0;
         if (m_busy) begin
            if (cancel_i) begin
               m_busy = 1'b0;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_busy = 1'b0;
                  m_hi   = p_hi;
                  m_lo   = p_lo;
                  m_done = 1'b1;
                  m_div0 = p_div0;
               end
            end
         end else if (start_i) begin
            if (op_i < 3'd4) begin
               {p_div0, p_hi, p_lo} = ref_op(op_i, a_i, b_i);
               m_busy = 1'b1;
               m_left = W + 2;
            end else if (op_i == 3'd4) begin
               m_hi = a_i;
            end else if (op_i == 3'd5) begin
               m_lo = a_i;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_busy", 64'(busy_o), 64'(m_busy));
         check("model_done", 64'(done_o), 64'(m_done));
         check("model_div0", 64'(div0_o), 64'(m_div0));
         check("model_hi",   64'(hi_o),   64'(m_hi));
         check("model_lo",   64'(lo_o),   64'(m_lo));
      end
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      start_i = 1'b1; op_i = o; a_i = x; b_i = y;
      @(posedge clk);
      #2 start_i = 1'b0;
   endtask

   // Counts edges after the accept edge until done_o is seen; returns at that negedge.
   task automatic wait_done(input string name, output int lat);
      lat = 0;
      while (1) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done_o) break;
         if (lat > 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done_o expected done_o within 200 cycles", name);
            break;
         end
      end
   endtask

   task automatic run_check(input string name, input logic [2:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] eh,
                            input logic [W-1:0] el, input logic ed);
      int lat;
      issue(o, x, y);
      wait_done(name, lat);
      check({name, "_lat"},  64'(lat),    64'(W + 2));
      check({name, "_hi"},   64'(hi_o),   64'(eh));
      check({name, "_lo"},   64'(lo_o),   64'(el));
      check({name, "_div0"}, 64'(div0_o), 64'(ed));
   endtask

   function automatic logic [W-1:0] rnd_val();
      case ($urandom_range(0, 9))
         0:       return '0;
         1:       return ONES;
         2:       return MIN;
         3:       return ~MIN;
         4:       return W'($urandom_range(0, 20));
         5:       return -W'($urandom_range(1, 20));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int lat;
      int ndone;
      rst_n = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; cancel_i = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      #20;
      check("rst_busy", 64'(busy_o), 64'(0));
      check("rst_done", 64'(done_o), 64'(0));
      check("rst_hi",   64'(hi_o),   64'(0));
      check("rst_lo",   64'(lo_o),   64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      run_check("multu_max", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      run_check("mult_neg",  3'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      run_check("div_neg",   3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_check("divu_zero", 3'd2, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1);
      run_check("div_wrap",  3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      run_check("div_zero_neg", 3'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

      // start held high during busy, then accepted again in the done cycle
      issue(3'd0, 32'd3, 32'd5);
      start_i = 1'b1; op_i = 3'd2; a_i = 32'd1000; b_i = 32'd9;
      wait_done("hold", lat);
      check("hold_lat", 64'(lat), 64'(W + 2));
      check("hold_lo",  64'(lo_o), 64'(32'hF));
      @(posedge clk);
      #2 start_i = 1'b0;
      wait_done("b2b", lat);
      check("b2b_lat", 64'(lat),  64'(W + 2));
      check("b2b_lo",  64'(lo_o), 64'(32'd111));
      check("b2b_hi",  64'(hi_o), 64'(32'd1));

      // MTHI, then a cancelled multiply
      issue(3'd4, 32'h12345678, 32'd0);
      @(negedge clk);
      check("mthi_hi",   64'(hi_o),   64'(32'h12345678));
      check("mthi_busy", 64'(busy_o), 64'(0));
      issue(3'd0, 32'hDEAD, 32'hBEEF);
      repeat (10) @(posedge clk);
      #2 cancel_i = 1'b1;
      @(posedge clk);
      #2 cancel_i = 1'b0;
      @(negedge clk);
      check("cancel_busy", 64'(busy_o), 64'(0));
      check("cancel_hi",   64'(hi_o),   64'(32'h12345678));
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done_o) ndone++;
      end
      check("cancel_nodone", 64'(ndone), 64'(0));

      // reset in the middle of a calculation
      issue(3'd1, 32'hFFFF1234, 32'h00ABCDEF);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy_o), 64'(0));
      check("mid_rst_done", 64'(done_o), 64'(0));
      check("mid_rst_div0", 64'(div0_o), 64'(0));
      check("mid_rst_hi",   64'(hi_o),   64'(0));
      check("mid_rst_lo",   64'(lo_o),   64'(0));
      @(negedge clk);
      #3 rst_n = 1'b1;
      run_check("divu_100_7", 3'd2, 32'd100, 32'd7, 32'd2, 32'hE, 1'b0);

      // randomized traffic; cancel is never combined with start
      for (int c = 0; c < 6000; c++) begin
         int r;
         @(posedge clk);
         #2;
         start_i  = 1'b0;
         cancel_i = 1'b0;
         r = $urandom_range(0, 99);
         if (r < 1) begin
            cancel_i = 1'b1;
         end else if (r < 30) begin
            start_i = 1'b1;
            op_i    = 3'($urandom_range(0, 7));
            a_i     = rnd_val();
            b_i     = rnd_val();
         end
      end
      @(posedge clk);
      #2 start_i = 1'b0; cancel_i = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
